// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive bit-processing path:
// line-state codes and the receive FSM encoding.
package usb_rx_pkg;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ABORT
  } rx_state_e;
endpackage

// File: rtl/usb_rx_unstuff.sv
// NRZI decoder and consecutive-ones counter. Decodes the current J/K sample
// combinationally and flags a stuffed bit or a stuffing violation.
module usb_rx_unstuff (
  input  logic clk,
  input  logic rst_n,
  input  logic level,      // 1 = J, 0 = K
  input  logic strobe,     // J/K sample present
  input  logic clear,      // restart ones counting at the current bit
  output logic dec_bit,
  output logic bit_ok,
  output logic stuff_drop,
  output logic stuff_err
);
  logic       prev_q, prev_d;
  logic [2:0] ones_q, ones_d;

  always_comb begin
    dec_bit    = (level == prev_q);
    stuff_drop = strobe && (ones_q == 3'd6) && !dec_bit;
    stuff_err  = strobe && (ones_q == 3'd6) && dec_bit;
    bit_ok     = strobe && (ones_q != 3'd6);
    prev_d     = prev_q;
    ones_d     = ones_q;
    if (strobe) begin
      prev_d = level;
      if (clear)        ones_d = {2'b00, dec_bit};
      else if (!dec_bit) ones_d = 3'd0;
      else if (ones_q != 3'd6) ones_d = ones_q + 3'd1;
    end
  end

  // Idle line is J, so the first K of SYNC decodes as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b1;
      ones_q <= 3'd0;
    end else begin
      prev_q <= prev_d;
      ones_q <= ones_d;
    end
  end
endmodule

// File: rtl/usb_rx_bitproc.sv
// USB receive bit processing: SYNC detect, NRZI decode, bit unstuffing,
// LSB-first byte assembly and EOP / error detection. All outputs registered.
module usb_rx_bitproc
  import usb_rx_pkg::*;
#(
  parameter int SE0_BITS  = 2,
  parameter int MAX_BYTES = 1027
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_valid,
  input  logic [1:0] line_state,
  output logic       rx_active,
  output logic       crc_init,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pkt_end,
  output logic       err_stuff,
  output logic       err_align,
  output logic       err_eop,
  output logic       err_babble
);
  localparam int SE0_W = (SE0_BITS < 2) ? 1 : $clog2(SE0_BITS + 1);
  localparam int BC_W  = $clog2(MAX_BYTES + 2);
  localparam logic [SE0_W-1:0] SE0_MAX = SE0_W'(SE0_BITS);
  localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(MAX_BYTES);
  localparam logic [BC_W-1:0]  BC_SAT  = BC_W'(MAX_BYTES + 1);

  rx_state_e        state_q, state_d;
  logic             rx_active_q, rx_active_d;
  logic             crc_init_q, crc_init_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             pkt_end_q, pkt_end_d;
  logic             err_stuff_q, err_stuff_d;
  logic             err_align_q, err_align_d;
  logic             err_eop_q, err_eop_d;
  logic             err_babble_q, err_babble_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [SE0_W-1:0] se0_cnt_q, se0_cnt_d;

  logic is_jk, is_se0, uclear;
  logic dec_bit, bit_ok, stuff_drop, stuff_err;

  assign is_jk  = line_state[0] ^ line_state[1];
  assign is_se0 = (line_state == LS_SE0);

  usb_rx_unstuff u_unstuff (
    .clk        (clk),
    .rst_n      (rst_n),
    .level      (line_state == LS_J),
    .strobe     (line_valid && is_jk),
    .clear      (uclear),
    .dec_bit    (dec_bit),
    .bit_ok     (bit_ok),
    .stuff_drop (stuff_drop),
    .stuff_err  (stuff_err)
  );

  always_comb begin
    state_d      = state_q;
    rx_active_d  = rx_active_q;
    bit_out_d    = bit_out_q;
    byte_out_d   = byte_out_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    se0_cnt_d    = se0_cnt_q;
    crc_init_d   = 1'b0;
    bit_valid_d  = 1'b0;
    byte_valid_d = 1'b0;
    pkt_end_d    = 1'b0;
    err_stuff_d  = 1'b0;
    err_align_d  = 1'b0;
    err_eop_d    = 1'b0;
    err_babble_d = 1'b0;
    uclear       = 1'b0;
    if (line_valid) begin
      unique case (state_q)
        ST_IDLE: if (line_state == LS_K) state_d = ST_SYNC;
        ST_SYNC: begin
          if (!is_jk) state_d = ST_IDLE;
          else if (dec_bit) begin
            crc_init_d  = 1'b1;
            rx_active_d = 1'b1;
            uclear      = 1'b1;
            bit_cnt_d   = 3'd0;
            byte_cnt_d  = '0;
            state_d     = ST_DATA;
          end
        end
        ST_DATA: begin
          if (is_se0) begin
            se0_cnt_d = SE0_W'(1);
            state_d   = ST_EOP;
          end else if (!is_jk) begin
            err_eop_d = 1'b1;
            se0_cnt_d = '0;
            state_d   = ST_ABORT;
          end else if (stuff_err) begin
            err_stuff_d = 1'b1;
            se0_cnt_d   = '0;
            state_d     = ST_ABORT;
          end else if (stuff_drop) begin
            bit_valid_d = 1'b0;
          end else if (bit_ok) begin
            sr_d      = {dec_bit, sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && byte_cnt_q >= BC_MAX) begin
              // Overlong packet: the offending byte is not delivered.
              err_babble_d = 1'b1;
              byte_cnt_d   = BC_SAT;
              se0_cnt_d    = '0;
              state_d      = ST_ABORT;
            end else begin
              bit_valid_d = 1'b1;
              bit_out_d   = dec_bit;
              if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_out_d   = sr_d;
                byte_cnt_d   = byte_cnt_q + BC_W'(1);
              end
            end
          end
        end
        ST_EOP: begin
          if (is_se0) begin
            if (se0_cnt_q < SE0_MAX) se0_cnt_d = se0_cnt_q + SE0_W'(1);
          end else if (line_state == LS_J && se0_cnt_q >= SE0_MAX) begin
            pkt_end_d   = 1'b1;
            err_align_d = (bit_cnt_q != 3'd0);
            rx_active_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            err_eop_d = 1'b1;
            se0_cnt_d = '0;
            state_d   = ST_ABORT;
          end
        end
        ST_ABORT: begin
          // Recover only after a full SE0 -> J transition.
          if (is_se0) se0_cnt_d = SE0_W'(1);
          else if (line_state == LS_J && se0_cnt_q != '0) begin
            rx_active_d = 1'b0;
            state_d     = ST_IDLE;
          end else se0_cnt_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rx_active_q  <= 1'b0;
      crc_init_q   <= 1'b0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      pkt_end_q    <= 1'b0;
      err_stuff_q  <= 1'b0;
      err_align_q  <= 1'b0;
      err_eop_q    <= 1'b0;
      err_babble_q <= 1'b0;
      sr_q         <= 8'h00;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= '0;
      se0_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rx_active_q  <= rx_active_d;
      crc_init_q   <= crc_init_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      pkt_end_q    <= pkt_end_d;
      err_stuff_q  <= err_stuff_d;
      err_align_q  <= err_align_d;
      err_eop_q    <= err_eop_d;
      err_babble_q <= err_babble_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      se0_cnt_q    <= se0_cnt_d;
    end
  end

  assign rx_active  = rx_active_q;
  assign crc_init   = crc_init_q;
  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign pkt_end    = pkt_end_q;
  assign err_stuff  = err_stuff_q;
  assign err_align  = err_align_q;
  assign err_eop    = err_eop_q;
  assign err_babble = err_babble_q;
endmodule

// File: tb/tb_usb_rx_bitproc.sv
// Scoreboard bench for usb_rx_bitproc: the driver queues expected output
// events, a negedge monitor pops and compares every observed pulse.
module tb_usb_rx_bitproc;
  localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10, SE1 = 2'b11;
  localparam int K_CRC = 0, K_BIT = 1, K_BYTE = 2, K_END = 3, K_STUFF = 4,
                 K_EOP = 5, K_BABBLE = 6, K_ALIGN_ONLY = 7;

  typedef struct { int kind; logic [7:0] data; } ev_t;

  logic       clk = 1'b0, rst_n = 1'b0, line_valid = 1'b0;
  logic [1:0] line_state = J;
  logic       rx_active, crc_init, bit_out, bit_valid, byte_valid, pkt_end;
  logic       err_stuff, err_align, err_eop, err_babble;
  logic [7:0] byte_out;

  int  checks = 0, errors = 0;
  ev_t exp_q[$];
  logic lvl = 1'b1;  // current encoded line level, 1 = J
  int   ones = 0;

  usb_rx_bitproc #(.SE0_BITS(2), .MAX_BYTES(1027)) dut (
    .clk(clk), .rst_n(rst_n), .line_valid(line_valid), .line_state(line_state),
    .rx_active(rx_active), .crc_init(crc_init), .bit_out(bit_out), .bit_valid(bit_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .pkt_end(pkt_end), .err_stuff(err_stuff),
    .err_align(err_align), .err_eop(err_eop), .err_babble(err_babble)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, pending events %0d required 0", exp_q.size());
    $fatal(1, "timeout");
  end

  task automatic take(input int k, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %02h, required none (t=%0t)", k, d, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data != d) begin
        errors++;
        $display("FAIL event_order: got kind %0d data %02h, required kind %0d data %02h (t=%0t)",
                 k, d, e.kind, e.data, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (crc_init)   take(K_CRC, 8'h00);
      if (bit_valid)  take(K_BIT, {7'b0, bit_out});
      if (byte_valid) take(K_BYTE, byte_out);
      if (pkt_end)    take(K_END, {7'b0, err_align});
      else if (err_align) take(K_ALIGN_ONLY, 8'h00);
      if (err_stuff)  take(K_STUFF, 8'h00);
      if (err_eop)    take(K_EOP, 8'h00);
      if (err_babble) take(K_BABBLE, 8'h00);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic ls_tick(input logic [1:0] ls);
    line_valid = 1'b1; line_state = ls;
    @(posedge clk); #1;
    line_valid = 1'b0;
    @(posedge clk); #1;
    if (ls == J) lvl = 1'b1;
    if (ls == K) lvl = 1'b0;
  endtask

  task automatic send_raw(input logic b);
    if (!b) lvl = ~lvl;
    ls_tick(lvl ? J : K);
  endtask

  // Data bit with transmitter-side stuffing.
  task automatic send_dbit(input logic b);
    send_raw(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin send_raw(1'b0); ones = 0; end
  endtask

  task automatic sync();
    push(K_CRC, 8'h00);
    for (int i = 0; i < 7; i++) send_raw(1'b0);
    send_raw(1'b1);
    ones = 1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      push(K_BIT, {7'b0, b[i]});
      if (i == 7) push(K_BYTE, b);
      send_dbit(b[i]);
    end
  endtask

  task automatic eop(input logic align);
    push(K_END, {7'b0, align});
    ls_tick(SE0); ls_tick(SE0); ls_tick(J);
  endtask

  task automatic recover();
    ls_tick(SE0); ls_tick(J);
  endtask

  initial begin
    logic [7:0] ext;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {14'b0, rx_active, crc_init, bit_out, bit_valid, byte_out, byte_valid,
        pkt_end, err_stuff, err_align, err_eop, err_babble}, 32'h0);
    rst_n = 1'b1;
    ls_tick(J); ls_tick(J);

    // Basic packet 8'hA5.
    sync();
    chk("rx_active_after_sync", {31'b0, rx_active}, 32'h1);
    send_byte(8'hA5);
    eop(1'b0);
    chk("rx_active_after_eop", {31'b0, rx_active}, 32'h0);
    chk("byte_out_hold", {24'b0, byte_out}, 32'hA5);
    ls_tick(J);

    // Stuffing: two 8'hFF bytes, and a stuffed bit right before SE0.
    sync(); send_byte(8'hFF); send_byte(8'hFF); eop(1'b0);
    sync(); send_byte(8'hFC); eop(1'b0);

    // Stuffing violation: six raw 1s after SYNC's trailing 1.
    sync();
    for (int i = 0; i < 5; i++) push(K_BIT, 8'h01);
    push(K_STUFF, 8'h00);
    for (int i = 0; i < 6; i++) send_raw(1'b1);
    chk("rx_active_in_abort", {31'b0, rx_active}, 32'h1);
    recover();
    chk("rx_active_after_abort", {31'b0, rx_active}, 32'h0);

    // Misaligned EOP: 8'hC3 then bits 1,0,1.
    sync(); send_byte(8'hC3);
    ext = 8'h05;
    for (int i = 0; i < 3; i++) begin push(K_BIT, {7'b0, ext[i]}); send_dbit(ext[i]); end
    eop(1'b1);

    // Short SE0 run.
    sync(); send_byte(8'h5A);
    push(K_EOP, 8'h00);
    ls_tick(SE0); ls_tick(J);
    chk("rx_active_short_se0", {31'b0, rx_active}, 32'h1);
    recover();
    chk("rx_active_after_short_se0", {31'b0, rx_active}, 32'h0);

    // SE1 mid-packet.
    sync(); send_byte(8'h3C);
    push(K_EOP, 8'h00);
    ls_tick(SE1);
    recover();

    // Reset mid-byte, then a clean 8'h2D packet.
    sync();
    ext = 8'h96;
    for (int i = 0; i < 4; i++) begin push(K_BIT, {7'b0, ext[i]}); send_dbit(ext[i]); end
    rst_n = 1'b0;
    #2;
    chk("reset_mid_packet", {14'b0, rx_active, crc_init, bit_out, bit_valid, byte_out, byte_valid,
        pkt_end, err_stuff, err_align, err_eop, err_babble}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held_rx_active", {31'b0, rx_active}, 32'h0);
    rst_n = 1'b1; lvl = 1'b1; ones = 0;
    ls_tick(J);
    sync(); send_byte(8'h2D); eop(1'b0);
    chk("byte_after_reset", {24'b0, byte_out}, 32'h2D);

    // Babble: 1027 bytes accepted, the 1028th aborts.
    sync();
    for (int n = 0; n < 1027; n++) send_byte(8'h00);
    for (int i = 0; i < 7; i++) push(K_BIT, 8'h00);
    push(K_BABBLE, 8'h00);
    for (int i = 0; i < 8; i++) send_dbit(1'b0);
    chk("rx_active_babble", {31'b0, rx_active}, 32'h1);
    recover();
    chk("rx_active_after_babble", {31'b0, rx_active}, 32'h0);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
